// File: rtl/ident_scanner_if.sv
// ---------------------------------------------------------------------------
// ident_scanner_if
// Character-stream / token-report bundle for ident_scanner.
//   char_valid_i  : character on char_i is sampled this cycle
//   char_i[7:0]   : ASCII character
//   flush_i       : end-of-stream, acts as a separator (char discarded)
//   out_o         : current partial token is a legal identifier
//   tok_done_o    : one-cycle pulse, a legal identifier just completed
//   tok_len_o     : length of last completed identifier (held)
//   tok_cnt_o     : saturating count of completed identifiers
// Modports: slave = the scanner, master = the character source / consumer.
// Signal suffixes are relative to the scanner.
// ---------------------------------------------------------------------------
interface ident_scanner_if #(
    parameter int LEN_W = 5,
    parameter int CNT_W = 16
);
    logic             char_valid_i;
    logic [7:0]       char_i;
    logic             flush_i;
    logic             out_o;
    logic             tok_done_o;
    logic [LEN_W-1:0] tok_len_o;
    logic [CNT_W-1:0] tok_cnt_o;

    modport slave (
        input  char_valid_i, char_i, flush_i,
        output out_o, tok_done_o, tok_len_o, tok_cnt_o
    );

    modport master (
        output char_valid_i, char_i, flush_i,
        input  out_o, tok_done_o, tok_len_o, tok_cnt_o
    );
endinterface

// File: rtl/ident_scanner.sv
// ---------------------------------------------------------------------------
// ident_scanner
// Streaming identifier recogniser: one ASCII char per accepted cycle, tracks
// whether the current token is a letter followed by letters/digits, limited
// to MAX_LEN characters. Reports completion with a pulse, length and a
// saturating count. All outputs are registered (1-cycle latency).
//
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, highest priority
//   bus    : ident_scanner_if.slave (char_valid_i, char_i, flush_i in;
//            out_o, tok_done_o, tok_len_o, tok_cnt_o out)
//
// Optional feature macro: IDENT_UNDERSCORE_EN
//   defined   -> '_' (0x5F) counts as a letter
//   undefined -> '_' is illegal
// ---------------------------------------------------------------------------
module ident_scanner #(
    parameter int MAX_LEN = 31,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 16
) (
    input  logic           clk,
    input  logic           reset,
    ident_scanner_if.slave bus
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALPHA,
        ST_MIXED,
        ST_BAD
    } state_t;

    typedef enum logic [1:0] {
        CLS_LETTER,
        CLS_DIGIT,
        CLS_SEP,
        CLS_ILLEGAL
    } cls_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             complete;
    cls_t             cls;

    logic             out_q;
    logic             tok_done_q;
    logic [LEN_W-1:0] tok_len_q;
    logic [CNT_W-1:0] tok_cnt_q;

    // Character classification
    always_comb begin
        cls = CLS_ILLEGAL;
        if ((bus.char_i >= 8'h41 && bus.char_i <= 8'h5A) ||
            (bus.char_i >= 8'h61 && bus.char_i <= 8'h7A))
            cls = CLS_LETTER;
`ifdef IDENT_UNDERSCORE_EN
        else if (bus.char_i == 8'h5F)
            cls = CLS_LETTER;
`endif
        else if (bus.char_i >= 8'h30 && bus.char_i <= 8'h39)
            cls = CLS_DIGIT;
        else if (bus.char_i == 8'h20 || bus.char_i == 8'h09 ||
                 bus.char_i == 8'h0A || bus.char_i == 8'h0D ||
                 bus.char_i == 8'h00)
            cls = CLS_SEP;
    end

    // Next state / length / completion decision
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        complete = 1'b0;
        if (bus.flush_i) begin
            // flush is a separator regardless of char_valid; char is dropped
            complete = (state_q == ST_ALPHA) || (state_q == ST_MIXED);
            state_d  = ST_IDLE;
            len_d    = '0;
        end else if (bus.char_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (cls == CLS_LETTER) begin
                        state_d = ST_ALPHA;
                        len_d   = LEN_W'(1);
                    end else if (cls != CLS_SEP) begin
                        state_d = ST_BAD;
                        len_d   = '0;
                    end
                end
                ST_ALPHA, ST_MIXED: begin
                    if (cls == CLS_LETTER || cls == CLS_DIGIT) begin
                        // One char past the limit poisons the token; len never wraps
                        if (len_q == MAX_LEN_L) begin
                            state_d = ST_BAD;
                            len_d   = '0;
                        end else begin
                            state_d = (cls == CLS_DIGIT || state_q == ST_MIXED)
                                      ? ST_MIXED : ST_ALPHA;
                            len_d   = len_q + LEN_W'(1);
                        end
                    end else if (cls == CLS_SEP) begin
                        complete = 1'b1;
                        state_d  = ST_IDLE;
                        len_d    = '0;
                    end else begin
                        state_d = ST_BAD;
                        len_d   = '0;
                    end
                end
                default: begin // ST_BAD
                    if (cls == CLS_SEP)
                        state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            out_q      <= 1'b0;
            tok_done_q <= 1'b0;
            tok_len_q  <= '0;
            tok_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            // out reflects the state being entered so it lines up with state_q
            out_q      <= (state_d == ST_ALPHA) || (state_d == ST_MIXED);
            tok_done_q <= complete;
            if (complete) begin
                tok_len_q <= len_q;
                if (tok_cnt_q != {CNT_W{1'b1}})
                    tok_cnt_q <= tok_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_o      = out_q;
    assign bus.tok_done_o = tok_done_q;
    assign bus.tok_len_o  = tok_len_q;
    assign bus.tok_cnt_o  = tok_cnt_q;

endmodule

// File: tb/tb_ident_scanner.sv
// ---------------------------------------------------------------------------
// tb_ident_scanner
// Two scanners share one character stream: dut_a with default parameters
// and dut_b with MAX_LEN=4, LEN_W=3, CNT_W=2 (length limit and counter
// saturation reachable quickly). A token-buffer model predicts every output
// on every cycle; literal checks after each directed vector pin the model.
// ---------------------------------------------------------------------------
module tb_ident_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cv  = 1'b0;
    logic [7:0] ch  = 8'h00;
    logic       fl  = 1'b0;
    bit         chk_en = 1'b0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ident_scanner_if #(.LEN_W(5), .CNT_W(16)) if_a ();
    ident_scanner_if #(.LEN_W(3), .CNT_W(2))  if_b ();

    assign if_a.char_valid_i = cv;
    assign if_a.char_i       = ch;
    assign if_a.flush_i      = fl;
    assign if_b.char_valid_i = cv;
    assign if_b.char_i       = ch;
    assign if_b.flush_i      = fl;

    ident_scanner #(.MAX_LEN(31), .LEN_W(5), .CNT_W(16)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (if_a.slave)
    );

    ident_scanner #(.MAX_LEN(4), .LEN_W(3), .CNT_W(2)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (if_b.slave)
    );

    // ------------------------------------------------------------------
    // Model: the token is the list of chars since the last separator.
    // It is a legal identifier iff non-empty, starts with a letter, holds
    // only letters/digits and is no longer than the length limit.
    // ------------------------------------------------------------------
    byte tok_q[$];
    int  ml[2]   = '{31, 4};
    int  cmax[2] = '{65535, 3};
    int  exp_out[2], exp_done[2], exp_len[2], exp_cnt[2];

    function automatic bit is_letter(input byte c);
`ifdef IDENT_UNDERSCORE_EN
        if (c == 8'h5F) return 1'b1;
`endif
        return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
    endfunction

    function automatic bit is_digit(input byte c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic bit is_sep(input byte c);
        return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D || c == 8'h00;
    endfunction

    function automatic bit legal(input byte q[$], input int maxl);
        if (q.size() == 0 || q.size() > maxl) return 1'b0;
        if (!is_letter(q[0])) return 1'b0;
        foreach (q[i])
            if (!is_letter(q[i]) && !is_digit(q[i])) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            exp_out[k] = 0; exp_done[k] = 0; exp_len[k] = 0; exp_cnt[k] = 0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            tok_q.delete();
            for (int k = 0; k < 2; k++) begin
                exp_out[k] = 0; exp_done[k] = 0; exp_len[k] = 0; exp_cnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) exp_done[k] = 0;
            if (fl || (cv && is_sep(ch))) begin
                for (int k = 0; k < 2; k++) begin
                    if (legal(tok_q, ml[k])) begin
                        exp_done[k] = 1;
                        exp_len[k]  = tok_q.size();
                        if (exp_cnt[k] < cmax[k]) exp_cnt[k]++;
                    end
                end
                tok_q.delete();
            end else if (cv) begin
                tok_q.push_back(ch);
            end
            for (int k = 0; k < 2; k++) exp_out[k] = legal(tok_q, ml[k]);
        end
    end

    task automatic cmp(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Per-cycle compare of both DUTs against the model, away from posedge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("a.out",      int'(if_a.out_o),      exp_out[0]);
            cmp("a.tok_done", int'(if_a.tok_done_o), exp_done[0]);
            cmp("a.tok_len",  int'(if_a.tok_len_o),  exp_len[0]);
            cmp("a.tok_cnt",  int'(if_a.tok_cnt_o),  exp_cnt[0]);
            cmp("b.out",      int'(if_b.out_o),      exp_out[1]);
            cmp("b.tok_done", int'(if_b.tok_done_o), exp_done[1]);
            cmp("b.tok_len",  int'(if_b.tok_len_o),  exp_len[1]);
            cmp("b.tok_cnt",  int'(if_b.tok_cnt_o),  exp_cnt[1]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change on negedge, sampled on next posedge
    // ------------------------------------------------------------------
    task automatic send(input byte c, input bit v = 1'b1, input bit f = 1'b0);
        @(negedge clk);
        ch = c; cv = v; fl = f;
        $display("tx: char=0x%02h valid=%0b flush=%0b reset=%0b", c, v, f, rst);
    endtask

    task automatic idle();
        send(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cv = 1'b0; fl = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        settle();
        cmp("lit.reset.out",  int'(if_a.out_o),      0);
        cmp("lit.reset.done", int'(if_a.tok_done_o), 0);
        cmp("lit.reset.len",  int'(if_a.tok_len_o),  0);
        cmp("lit.reset.cnt",  int'(if_a.tok_cnt_o),  0);
        @(negedge clk);
        rst = 1'b0;

        // "ab1 " -> identifier of length 3
        send("a"); settle(); cmp("lit.ab1.out_a", int'(if_a.out_o), 1);
        send("b"); settle(); cmp("lit.ab1.out_b", int'(if_a.out_o), 1);
        send("1"); settle(); cmp("lit.ab1.out_1", int'(if_a.out_o), 1);
        send(" "); settle();
        cmp("lit.ab1.done", int'(if_a.tok_done_o), 1);
        cmp("lit.ab1.len",  int'(if_a.tok_len_o),  3);
        cmp("lit.ab1.cnt",  int'(if_a.tok_cnt_o),  1);
        cmp("lit.ab1.out",  int'(if_a.out_o),      0);
        idle(); settle();
        cmp("lit.ab1.pulse_end", int'(if_a.tok_done_o), 0);
        cmp("lit.ab1.len_held",  int'(if_a.tok_len_o),  3);

        // "1ab " -> bad token, nothing reported
        send_str("1ab"); settle();
        cmp("lit.1ab.out", int'(if_a.out_o), 0);
        send(" "); settle();
        cmp("lit.1ab.done", int'(if_a.tok_done_o), 0);
        cmp("lit.1ab.cnt",  int'(if_a.tok_cnt_o),  1);

        // Length limit on dut_b (MAX_LEN=4)
        send_str("abcd "); settle();
        cmp("lit.abcd.b_done", int'(if_b.tok_done_o), 1);
        cmp("lit.abcd.b_len",  int'(if_b.tok_len_o),  4);
        send_str("abcde"); settle();
        cmp("lit.abcde.b_out", int'(if_b.out_o), 0);
        cmp("lit.abcde.a_out", int'(if_a.out_o), 1);
        send(" "); settle();
        cmp("lit.abcde.b_done", int'(if_b.tok_done_o), 0);
        cmp("lit.abcde.a_len",  int'(if_a.tok_len_o),  5);
        cmp("lit.abcde.b_cnt",  int'(if_b.tok_cnt_o),  2);

        // Gapped "x" then flush
        send("x"); idle(); idle(); idle(); settle();
        cmp("lit.gap.out",  int'(if_a.out_o),      1);
        cmp("lit.gap.done", int'(if_a.tok_done_o), 0);
        send(8'h00, 1'b0, 1'b1); settle();
        cmp("lit.flush.done", int'(if_a.tok_done_o), 1);
        cmp("lit.flush.len",  int'(if_a.tok_len_o),  1);
        // Flush with a valid letter: letter discarded, token completes
        send("q"); send("z", 1'b1, 1'b1); settle();
        cmp("lit.flushv.done", int'(if_a.tok_done_o), 1);
        cmp("lit.flushv.len",  int'(if_a.tok_len_o),  1);
        cmp("lit.flushv.out",  int'(if_a.out_o),      0);
        idle(); idle();

        // Counter saturation on dut_b (CNT_W=2)
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_str("a "); settle();
            cmp("lit.sat.b_done", int'(if_b.tok_done_o), 1);
            cmp("lit.sat.b_cnt",  int'(if_b.tok_cnt_o),  (i < 3) ? i + 1 : 3);
        end
        cmp("lit.sat.a_cnt", int'(if_a.tok_cnt_o), 5);

        // Underscore handling
        send_str("a_b "); settle();
`ifdef IDENT_UNDERSCORE_EN
        cmp("lit.us.done", int'(if_a.tok_done_o), 1);
        cmp("lit.us.len",  int'(if_a.tok_len_o),  3);
`else
        cmp("lit.us.done", int'(if_a.tok_done_o), 0);
        cmp("lit.us.len",  int'(if_a.tok_len_o),  1);
`endif

        // Reset asserted while 'b' is presented mid-token
        send("a"); send("_");
        @(negedge clk);
        ch = "b"; cv = 1'b1; fl = 1'b0; rst = 1'b1;
        $display("tx: char=0x%02h valid=1 flush=0 reset=1", ch);
        settle();
        cmp("lit.rst.out",  int'(if_a.out_o),      0);
        cmp("lit.rst.done", int'(if_a.tok_done_o), 0);
        cmp("lit.rst.len",  int'(if_a.tok_len_o),  0);
        cmp("lit.rst.cnt",  int'(if_a.tok_cnt_o),  0);
        cmp("lit.rst.bcnt", int'(if_b.tok_cnt_o),  0);
        @(negedge clk);
        rst = 1'b0; cv = 1'b0;

        // Fresh identifier after reset, with tab separator
        send_str("Z9y"); send(8'h09); settle();
        cmp("lit.post.done", int'(if_a.tok_done_o), 1);
        cmp("lit.post.len",  int'(if_a.tok_len_o),  3);
        cmp("lit.post.cnt",  int'(if_a.tok_cnt_o),  1);
        idle(); idle();

        @(negedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ident_scanner.md
Name: ident_scanner

Overview:
- Streaming character recogniser: consumes one 8-bit ASCII character per accepted cycle and tracks whether the current token is a legal identifier (a letter followed by letters/digits).
- Parametrised successor of the single-character identifier FSM. Adds an input qualifier, a length limit, a flush control, and token completion reporting: pulse, length and saturating count.
- Sits between the character source and downstream parser/statistics logic.

Parameters:
- MAX_LEN, 31, maximum legal identifier length in characters (1..2^LEN_W-1).
- LEN_W, 5, width of length counter and tok_len.
- CNT_W, 16, width of completed-token counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- char_valid  in  1  char is sampled this cycle.
- char  in  8  ASCII character.
- flush  in  1  end-of-stream; behaves as a separator.
- out  out  1  high while the current partial token is a legal identifier.
- tok_done  out  1  one-cycle pulse: a legal identifier just completed.
- tok_len  out  LEN_W  length of the last completed identifier; held until the next tok_done.
- tok_cnt  out  CNT_W  number of completed identifiers; saturates at all-ones.

Behaviour:
- Character classes:
  - LETTER: 0x41-0x5A, 0x61-0x7A.
  - DIGIT: 0x30-0x39.
  - SEP: 0x20, 0x09, 0x0A, 0x0D, 0x00.
  - ILLEGAL: everything else.
- Reset: state=IDLE, len=0; out, tok_done, tok_len, tok_cnt all 0. Reset has priority over every other input.
- All outputs are registered. The effect of a char sampled at edge N is visible after edge N, so latency is 1 cycle.
- States:
  - IDLE: no token in progress.
  - ALPHA: letters only.
  - MIXED: letter first, then at least one digit.
  - BAD: token illegal, waiting for a separator.
- Transitions apply only when char_valid=1 and flush=0:
  - IDLE: LETTER -> ALPHA, len=1. DIGIT or ILLEGAL -> BAD. SEP -> IDLE.
  - ALPHA: LETTER -> ALPHA, len+1. DIGIT -> MIXED, len+1. SEP -> IDLE with completion. ILLEGAL -> BAD.
  - MIXED: LETTER or DIGIT -> MIXED, len+1. SEP -> IDLE with completion. ILLEGAL -> BAD.
  - BAD: SEP -> IDLE, no completion. Anything else -> BAD.
- Length limit: in ALPHA or MIXED with len==MAX_LEN, any further LETTER or DIGIT -> BAD. len never wraps.
- Completion (next cycle):
  - tok_done=1; tok_len=len; tok_cnt+1 unless already all-ones; len cleared.
- flush=1 (any char_valid):
  - Treated as SEP; char is discarded.
  - From ALPHA or MIXED it causes completion; from BAD or IDLE it returns to IDLE silently.
- char_valid=0 and flush=0: state, len, tok_len and tok_cnt hold; tok_done=0.
- out=1 exactly when the registered state is ALPHA or MIXED.
- tok_done is never high for two consecutive cycles without a new token in between.
- Reset mid-token: the token is dropped, no tok_done, and tok_cnt clears.

Optional Feature:
- Macro: IDENT_UNDERSCORE_EN.
- Defined: '_' (0x5F) is classified as LETTER, so it may start or continue an identifier.
- Undefined: '_' is ILLEGAL and drives the token to BAD.

Test Plan:
- Reset, then "ab1 " (one char per cycle, char_valid=1) -> out=1 after 'a', 'b' and '1'; then tok_done pulse with tok_len=3, tok_cnt=1, out=0.
- "1ab " -> BAD after '1', out stays 0, no tok_done, tok_cnt unchanged.
- MAX_LEN=4: "abcd " -> tok_len=4. Then "abcde " -> BAD on 'e', no tok_done.
- "x" with char_valid gapped by idle cycles, then flush=1 -> state held during gaps; tok_done with tok_len=1 one cycle after the flush.
- CNT_W=2: five identifiers "a " repeated -> tok_cnt goes 1, 2, 3, 3, 3; tok_done still pulses each time.
- "a_b " with IDENT_UNDERSCORE_EN defined -> tok_len=3. Undefined -> BAD, no tok_done. Also assert reset on the cycle 'b' is presented -> all outputs 0 next cycle.
